wb_arbiter_2m: RTL and testbench
================================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, legal range 1..255, max cycles owner strobe may wait for s_ack.
REQ-004 SHALL have port clk  input  1  single block clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port m0_address  input  ADDR_WIDTH  master 0 (GPMC bridge) address.
REQ-007 SHALL have port m0_writedata  input  DATA_WIDTH  master 0 write data.
REQ-008 SHALL have port m0_readdata  output  DATA_WIDTH  master 0 read data.
REQ-009 SHALL have port m0_write  input  1  master 0 write enable (1 = write).
REQ-010 SHALL have port m0_strobe  input  1  master 0 valid transfer.
REQ-011 SHALL have port m0_cycle  input  1  master 0 bus request/cycle in progress.
REQ-012 SHALL have port m0_ack  output  1  master 0 acknowledge.
REQ-013 SHALL have port m1_address  input  ADDR_WIDTH  master 1 (on-FPGA master) address.
REQ-014 SHALL have port m1_writedata  input  DATA_WIDTH  master 1 write data.
REQ-015 SHALL have port m1_readdata  output  DATA_WIDTH  master 1 read data.
REQ-016 SHALL have port m1_write  input  1  master 1 write enable.
REQ-017 SHALL have port m1_strobe  input  1  master 1 valid transfer.
REQ-018 SHALL have port m1_cycle  input  1  master 1 bus request.
REQ-019 SHALL have port m1_ack  output  1  master 1 acknowledge.
REQ-020 SHALL have port s_address  output  ADDR_WIDTH  shared slave address.
REQ-021 SHALL have port s_writedata  output  DATA_WIDTH  shared slave write data.
REQ-022 SHALL have port s_readdata  input  DATA_WIDTH  shared slave read data.
REQ-023 SHALL have port s_write  output  1  shared slave write enable.
REQ-024 SHALL have port s_strobe  output  1  shared slave strobe.
REQ-025 SHALL have port s_cycle  output  1  shared slave cycle.
REQ-026 SHALL have port s_ack  input  1  shared slave acknowledge.
REQ-027 SHALL have port timeout_err  output  1  one-cycle pulse when a transfer is terminated by timeout.
REQ-028 SHALL have port grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1, 00 = idle).
Function
REQ-029 SHALL implement FSM states IDLE, OWN0, OWN1; grant = 00/01/10 respectively, registered.
REQ-030 SHALL in IDLE with only mX_cycle high move to OWNX next edge (1-cycle grant latency).
REQ-031 SHALL in IDLE with both cycles high grant the master not served last (round-robin); last-served register resets to m1 so m0 wins the first tie.
REQ-032 SHALL keep ownership while owner's cycle stays high across any number of strobes (bus lock); non-owner requests wait.
REQ-033 SHALL return to IDLE on the edge where owner's cycle is sampled low; no direct OWN0->OWN1 transition, so at least one IDLE cycle separates owners.
REQ-034 SHALL combinationally route owner's address, writedata, write, strobe, cycle to s_*; in IDLE drive all s_* outputs 0.
REQ-035 SHALL route s_readdata and s_ack (gated by owner strobe) to owner only; non-owner readdata = 0, ack = 0.
REQ-036 SHALL count, in an 8-bit counter, cycles with owner strobe high and s_ack low; clear on s_ack, owner strobe low, or state change.
REQ-037 SHALL when counter equals TIMEOUT and s_ack low: assert owner ack for exactly one cycle with owner readdata = 0, deassert s_strobe that cycle, pulse timeout_err, clear counter.
REQ-038 SHALL, if s_ack arrives in the same cycle the counter reaches TIMEOUT, pass the real ack/data and not pulse timeout_err.
REQ-039 SHALL ignore s_ack while in IDLE (no master ack, no error).
Reset
REQ-040 SHALL on reset high at a clock edge force IDLE, grant = 00, counter = 0, last-served = m1, timeout_err = 0, regardless of transfer in progress.
REQ-041 SHALL therefore hold all s_* outputs, m*_ack, m*_readdata at 0 in the cycle after reset, and re-arbitrate from IDLE after reset release.
Verification
REQ-042 SHALL cover: m0_cycle=1, strobe=1, write=1, addr=0x0010, data=0xA5A5 -> grant=01 next cycle, s_address=0x0010, s_writedata=0xA5A5, m0_ack follows s_ack.
REQ-043 SHALL cover: both cycles high from reset -> m0 granted first; after m0 drops cycle, one IDLE cycle, then grant=10; repeat tie -> m0.
REQ-044 SHALL cover: TIMEOUT=4, owner strobe high, s_ack held 0 -> m0_ack and timeout_err pulse on 4th waiting cycle, m0_readdata=0x0000.
REQ-045 SHALL cover: m1 requests during m0 locked burst of 3 strobes -> m1 stays ungranted, m1_ack=0 throughout, granted after m0 releases.
REQ-046 SHALL cover: reset asserted mid-transfer in OWN1 -> grant=00, s_cycle=0, m1_ack=0 next cycle; counter restarts at 0.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone classic bus bundle shared by both masters and the slave side of the arbiter.
// Handshake: strobe is the valid of a transfer and stays high until ack (the ready/complete
// strobe) is seen for one cycle; cycle frames a locked sequence of such transfers.
interface wb_arbiter_2m_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  write;
  logic                  strobe;
  logic                  cycle;
  logic                  ack;

  modport master (
    output address, writedata, write, strobe, cycle,
    input  readdata, ack
  );

  modport slave (
    input  address, writedata, write, strobe, cycle,
    output readdata, ack
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on ties, bus lock while cycle is held,
// and a per-transfer ack timeout that terminates a stuck strobe with zero read data.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_arbiter_2m_if.slave       m0,
  wb_arbiter_2m_if.slave       m1,
  wb_arbiter_2m_if.master      s,
  output logic                 timeout_err,
  output logic [1:0]           grant
);

  // State encoding doubles as the one-hot grant, so grant is the state register itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  last_q, last_d;  // 0 = m0 served last, 1 = m1
  logic [7:0]            cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] own_address;
  logic [DATA_WIDTH-1:0] own_writedata;
  logic                  own_write;
  logic                  own_strobe;
  logic                  own_cycle;
  logic                  timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0.cycle && (!m1.cycle || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1.cycle) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0:    if (!m0.cycle) state_d = IDLE;
      OWN1:    if (!m1.cycle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_address   = '0;
    own_writedata = '0;
    own_write     = 1'b0;
    own_strobe    = 1'b0;
    own_cycle     = 1'b0;
    case (state_q)
      OWN0: begin
        own_address   = m0.address;
        own_writedata = m0.writedata;
        own_write     = m0.write;
        own_strobe    = m0.strobe;
        own_cycle     = m0.cycle;
      end
      OWN1: begin
        own_address   = m1.address;
        own_writedata = m1.writedata;
        own_write     = m1.write;
        own_strobe    = m1.strobe;
        own_cycle     = m1.cycle;
      end
      default: ;
    endcase
  end

  // cnt_q holds completed wait cycles, so the current cycle is wait number cnt_q+1;
  // a late s_ack in the terminal cycle wins over the timeout.
  assign timeout = own_strobe && !s.ack && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    cnt_d = 8'd0;
    if (own_strobe && !s.ack && !timeout && (state_d == state_q))
      cnt_d = cnt_q + 8'd1;
  end

  assign s.address   = own_address;
  assign s.writedata = own_writedata;
  assign s.write     = own_write;
  assign s.strobe    = own_strobe && !timeout;
  assign s.cycle     = own_cycle;

  assign m0.ack      = (state_q == OWN0) && ((own_strobe && s.ack) || timeout);
  assign m1.ack      = (state_q == OWN1) && ((own_strobe && s.ack) || timeout);
  assign m0.readdata = ((state_q == OWN0) && !timeout) ? s.readdata : '0;
  assign m1.readdata = ((state_q == OWN1) && !timeout) ? s.readdata : '0;

  assign timeout_err = timeout;
  assign grant       = state_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with TIMEOUT=4: arbitration, lock, timeout and reset cases.
module tb_wb_arbiter_2m;
  localparam int AW = 16;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       timeout_err;
  logic [1:0] grant;
  int         n_checks = 0;
  int         n_errors = 0;

  wb_arbiter_2m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_bus ();
  wb_arbiter_2m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_bus ();
  wb_arbiter_2m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .timeout_err (timeout_err),
    .grant       (grant)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change 2 time units after the rising edge, checks 1 unit later
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_bus.address = '0; m0_bus.writedata = '0; m0_bus.write = 1'b0;
    m0_bus.strobe  = 1'b0; m0_bus.cycle = 1'b0;
    m1_bus.address = '0; m1_bus.writedata = '0; m1_bus.write = 1'b0;
    m1_bus.strobe  = 1'b0; m1_bus.cycle = 1'b0;
    s_bus.readdata = '0; s_bus.ack = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_cycle", 32'(s_bus.cycle), 32'h0);
    check("rst_m0_ack", 32'(m0_bus.ack), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);

    // single write by m0
    m0_bus.cycle = 1'b1; m0_bus.strobe = 1'b1; m0_bus.write = 1'b1;
    m0_bus.address = 16'h0010; m0_bus.writedata = 16'hA5A5;
    #1;
    check("lat_grant", 32'(grant), 32'h0);
    check("lat_s_strobe", 32'(s_bus.strobe), 32'h0);
    step(); #1;
    check("w_grant", 32'(grant), 32'h1);
    check("w_s_addr", 32'(s_bus.address), 32'h0010);
    check("w_s_wdata", 32'(s_bus.writedata), 32'hA5A5);
    check("w_s_write", 32'(s_bus.write), 32'h1);
    check("w_s_strobe", 32'(s_bus.strobe), 32'h1);
    check("w_m0_ack_lo", 32'(m0_bus.ack), 32'h0);
    s_bus.ack = 1'b1; s_bus.readdata = 16'h1234;
    #1;
    check("w_m0_ack_hi", 32'(m0_bus.ack), 32'h1);
    check("w_m0_rdata", 32'(m0_bus.readdata), 32'h1234);
    check("w_m1_ack", 32'(m1_bus.ack), 32'h0);
    check("w_m1_rdata", 32'(m1_bus.readdata), 32'h0);
    clear_inputs();
    step(); #1;
    check("w_idle", 32'(grant), 32'h0);
    s_bus.ack = 1'b1;
    #1;
    check("idle_ack_m0", 32'(m0_bus.ack), 32'h0);
    check("idle_ack_terr", 32'(timeout_err), 32'h0);
    s_bus.ack = 1'b0;

    // round-robin from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    m0_bus.cycle = 1'b1; m1_bus.cycle = 1'b1;
    step(); #1;
    check("rr_first_m0", 32'(grant), 32'h1);
    m0_bus.cycle = 1'b0;
    step(); #1;
    check("rr_gap_idle", 32'(grant), 32'h0);
    step(); #1;
    check("rr_then_m1", 32'(grant), 32'h2);
    check("rr_m0_rdata", 32'(m0_bus.readdata), 32'h0);
    m0_bus.cycle = 1'b1; m1_bus.cycle = 1'b0;
    step(); #1;
    check("rr_gap2_idle", 32'(grant), 32'h0);
    m1_bus.cycle = 1'b1;
    step(); #1;
    check("rr_tie_m0", 32'(grant), 32'h1);
    clear_inputs();
    step(); #1;
    check("rr_release", 32'(grant), 32'h0);

    // ack timeout on m0 read
    m0_bus.cycle = 1'b1; m0_bus.strobe = 1'b1; s_bus.readdata = 16'hBEEF;
    step();
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("to_wait%0d_ack", i), 32'(m0_bus.ack), 32'h0);
      check($sformatf("to_wait%0d_terr", i), 32'(timeout_err), 32'h0);
      step();
    end
    #1;
    check("to_ack", 32'(m0_bus.ack), 32'h1);
    check("to_terr", 32'(timeout_err), 32'h1);
    check("to_rdata", 32'(m0_bus.readdata), 32'h0);
    check("to_s_strobe", 32'(s_bus.strobe), 32'h0);
    check("to_s_cycle", 32'(s_bus.cycle), 32'h1);
    m0_bus.strobe = 1'b0;
    step(); #1;
    check("to_after_terr", 32'(timeout_err), 32'h0);
    check("to_after_ack", 32'(m0_bus.ack), 32'h0);

    // ack arriving on the last allowed cycle wins
    m0_bus.strobe = 1'b1;
    repeat (3) step();
    s_bus.ack = 1'b1; s_bus.readdata = 16'hC0DE;
    #1;
    check("late_ack", 32'(m0_bus.ack), 32'h1);
    check("late_rdata", 32'(m0_bus.readdata), 32'hC0DE);
    check("late_terr", 32'(timeout_err), 32'h0);
    check("late_s_strobe", 32'(s_bus.strobe), 32'h1);
    clear_inputs();
    step();

    // m1 waits through m0 locked burst
    m0_bus.cycle = 1'b1;
    step();
    m1_bus.cycle = 1'b1; m1_bus.strobe = 1'b1; m1_bus.address = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      m0_bus.strobe = 1'b1; m0_bus.address = 16'(16'h0100 + i);
      s_bus.ack = 1'b1;
      #1;
      check($sformatf("lock%0d_grant", i), 32'(grant), 32'h1);
      check($sformatf("lock%0d_addr", i), 32'(s_bus.address), 32'h0100 + 32'(i));
      check($sformatf("lock%0d_m0_ack", i), 32'(m0_bus.ack), 32'h1);
      check($sformatf("lock%0d_m1_ack", i), 32'(m1_bus.ack), 32'h0);
      step();
    end
    m0_bus.cycle = 1'b0; m0_bus.strobe = 1'b0; s_bus.ack = 1'b0;
    #1;
    check("lock_rel_m1_ack", 32'(m1_bus.ack), 32'h0);
    step(); #1;
    check("lock_idle", 32'(grant), 32'h0);
    step(); #1;
    check("lock_m1_grant", 32'(grant), 32'h2);
    check("lock_m1_addr", 32'(s_bus.address), 32'h0020);

    // reset in the middle of an m1 transfer
    repeat (2) step();
    reset = 1'b1;
    step(); #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_s_cycle", 32'(s_bus.cycle), 32'h0);
    check("mid_rst_s_strobe", 32'(s_bus.strobe), 32'h0);
    check("mid_rst_m1_ack", 32'(m1_bus.ack), 32'h0);
    reset = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("rst_wait%0d_m1_ack", i), 32'(m1_bus.ack), 32'h0);
      step();
    end
    #1;
    check("rst_to_grant", 32'(grant), 32'h2);
    check("rst_to_m1_ack", 32'(m1_bus.ack), 32'h1);
    check("rst_to_terr", 32'(timeout_err), 32'h1);
    check("rst_to_m1_rdata", 32'(m1_bus.readdata), 32'h0);
    clear_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
